hue_arbiter: RTL and testbench

Shares one `rgb2hue` pipeline between two RGB pixel sources, for example the front and rear camera streams. It arbitrates round-robin and drives the shared datapath's r/g/b inputs. Each pixel carries a source tag through a shift register matched to the pipeline latency. Results collect in a small result FIFO with valid/ready backpressure. The `rgb2hue` pipeline cannot stall, so credit counting keeps every issued pixel's result guaranteed a FIFO slot.

---
 rtl/vision_pkg.sv | 19 +
 rtl/hue_result_fifo.sv | 44 ++++
 rtl/hue_arbiter.sv | 97 +++++++++
 tb/tb_hue_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared pixel and hue types for the camera colour-analysis blocks.
package vision_pkg;

  localparam int PIX_W     = 8;
  localparam int HUE_W     = 20;
  localparam int HUE_FIXED = 4;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic valid;
    logic src;
  } hue_tag_t;

endpackage

// File: rtl/hue_result_fifo.sv
// First-word fall-through result FIFO; a write is visible on the cycle after it lands.
module hue_result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_en;

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign rd_en    = rd_valid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      count <= count + (AW+1)'(1);
      else if (!wr_en && rd_en) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hue_arbiter.sv
// Round-robin sharing of one rgb2hue pipeline between two pixel sources,
// with credit-protected result buffering since the pipeline cannot stall.
module hue_arbiter
  import vision_pkg::*;
#(
  parameter int WIDTH = HUE_W,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [23:0]      s0_rgb,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [23:0]      s1_rgb,
  output logic [7:0]       dp_r,
  output logic [7:0]       dp_g,
  output logic [7:0]       dp_b,
  input  logic [WIDTH-1:0] dp_h,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_hue,
  output logic             m_src
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] occ;
  logic [CW-1:0] fifo_count;
  logic          last;
  logic          credit, grant0, grant1, issue0, issue1, issue, pop;
  rgb_t          dp_q;
  hue_tag_t      tag [LAT+1];
  logic          fifo_wr;
  logic [WIDTH:0] fifo_din;
  logic [WIDTH:0] fifo_dout;

  // Credit is taken from the registered count only, so a same-cycle pop never frees a slot.
  assign credit   = (occ < FULL);
  assign grant0   = s0_valid && (!s1_valid || last);
  assign grant1   = s1_valid && (!s0_valid || !last);
  assign s0_ready = grant0 && credit && !rst;
  assign s1_ready = grant1 && credit && !rst;
  assign issue0   = s0_valid && s0_ready;
  assign issue1   = s1_valid && s1_ready;
  assign issue    = issue0 || issue1;
  assign pop      = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= '0;
      last <= 1'b1;
      dp_q <= '0;
      for (int i = 0; i <= LAT; i++) tag[i] <= '0;
    end else begin
      if (issue && !pop)      occ <= occ + CW'(1);
      else if (!issue && pop) occ <= occ - CW'(1);
      if (issue) begin
        dp_q <= issue1 ? rgb_t'(s1_rgb) : rgb_t'(s0_rgb);
        last <= issue1;
      end
      tag[0].valid <= issue;
      tag[0].src   <= issue1;
      for (int i = 1; i <= LAT; i++) tag[i] <= tag[i-1];
    end
  end

  assign dp_r = dp_q.r;
  assign dp_g = dp_q.g;
  assign dp_b = dp_q.b;

  assign fifo_wr  = tag[LAT].valid;
  assign fifo_din = {dp_h, tag[LAT].src};

  hue_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_din),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .rd_data  (fifo_dout),
    .count    (fifo_count)
  );

  assign m_hue = fifo_dout[WIDTH:1];
  assign m_src = fifo_dout[0];

  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst) fifo_count <= occ);

endmodule

// File: tb/tb_hue_arbiter.sv
// Randomised bench for hue_arbiter with a behavioural rgb2hue stand-in and a queue-based result model.
module tb_hue_arbiter;

  localparam int WIDTH = 20;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             s0_valid, s1_valid, s0_ready, s1_ready;
  logic [23:0]      s0_rgb, s1_rgb;
  logic [7:0]       dp_r, dp_g, dp_b;
  logic [WIDTH-1:0] dp_h;
  logic             m_valid, m_ready, m_src;
  logic [WIDTH-1:0] m_hue;

  hue_arbiter #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rgb(s0_rgb),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rgb(s1_rgb),
    .dp_r(dp_r), .dp_g(dp_g), .dp_b(dp_b), .dp_h(dp_h),
    .m_valid(m_valid), .m_ready(m_ready), .m_hue(m_hue), .m_src(m_src)
  );

  always #5 clk = ~clk;

  // Hue in degrees with 4 fractional bits, truncated.
  function automatic logic [WIDTH-1:0] hue16(input logic [23:0] p);
    int r, g, b, mx, mn, d, num;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    mx = (r > g) ? r : g; mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g; mn = (b < mn) ? b : mn;
    d = mx - mn;
    if (d == 0) return '0;
    if (mx == r) begin
      num = 960 * (g - b);
      if (num < 0) num += 5760 * d;
    end else if (mx == g) num = 960 * (b - r) + 1920 * d;
    else                  num = 960 * (r - g) + 3840 * d;
    return WIDTH'(num / d);
  endfunction

  // Stand-in for the shared rgb2hue pipeline.
  logic [WIDTH-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= hue16({dp_r, dp_g, dp_b});
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_h = pipe[LAT-1];

  typedef struct {
    logic [WIDTH-1:0] hue;
    bit               src;
    int               vis;
  } exp_t;

  exp_t             q[$];
  bit               last_m;
  int               edge_n;
  int               checks, errors;
  logic [WIDTH-1:0] seen_hue[$];
  bit               seen_src[$];
  bit               acc_src[$];
  logic [23:0]      acc_rgb[$];
  int               first_acc_edge, first_valid_edge;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    seen_hue.delete(); seen_src.delete(); acc_src.delete(); acc_rgb.delete();
    first_acc_edge = -1; first_valid_edge = -1;
  endtask

  task automatic cyc(input bit v0, input logic [23:0] p0, input bit v1, input logic [23:0] p1,
                     input bit mr);
    bit credit, e0, e1, ev;
    @(negedge clk);
    s0_valid = v0; s0_rgb = p0; s1_valid = v1; s1_rgb = p1; m_ready = mr;
    #1;
    credit = (q.size() < DEPTH);
    e0 = v0 && (!v1 || last_m) && credit;
    e1 = v1 && (!v0 || !last_m) && credit;
    ev = (q.size() > 0) && (q[0].vis <= edge_n);
    chk("s0_ready", 32'(s0_ready), 32'(e0));
    chk("s1_ready", 32'(s1_ready), 32'(e1));
    chk("m_valid", 32'(m_valid), 32'(ev));
    if (ev) begin
      chk("m_hue", 32'(m_hue), 32'(q[0].hue));
      chk("m_src", 32'(m_src), 32'(q[0].src));
    end
    if (m_valid && first_valid_edge < 0) first_valid_edge = edge_n;
    if (m_valid && m_ready) begin
      seen_hue.push_back(m_hue);
      seen_src.push_back(m_src);
    end
    if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
      acc_src.push_back(s1_valid && s1_ready);
      acc_rgb.push_back((s1_valid && s1_ready) ? p1 : p0);
      if (first_acc_edge < 0) first_acc_edge = edge_n + 1;
    end
    @(posedge clk);
    edge_n++;
    if (ev && mr) void'(q.pop_front());
    if (e0 || e1) begin
      q.push_back('{hue: hue16(e1 ? p1 : p0), src: e1, vis: edge_n + LAT + 1});
      last_m = e1;
    end
  endtask

  task automatic rnd_cyc(input int mr_pct);
    cyc($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 3) != 0, 24'($urandom),
        $urandom_range(0, 99) < mr_pct);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(s1_ready), 32'd0);
    chk("rst_dp", {8'h0, dp_r, dp_g, dp_b}, 32'd0);
    chk("rst_m_hue", 32'(m_hue), 32'd0);
    q.delete();
    last_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; edge_n = 0;
    last_m = 1'b1;
    clear_logs();
    rst = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; s0_rgb = '0; s1_rgb = '0; m_ready = 1'b0;
    #3;
    chk("init_m_valid", 32'(m_valid), 32'd0);
    chk("init_s0_ready", 32'(s0_ready), 32'd0);
    chk("init_s1_ready", 32'(s1_ready), 32'd0);
    chk("init_dp", {8'h0, dp_r, dp_g, dp_b}, 32'd0);
    chk("init_m_src", 32'(m_src), 32'd0);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst = 1'b0;

    // Both sources always valid: grants alternate, source 0 first after reset.
    clear_logs();
    for (int i = 0; i < 20; i++) cyc(1'b1, 24'($urandom), 1'b1, 24'($urandom), 1'b1);
    idle(10);
    chk("alt_acc_n", 32'(acc_src.size() >= 4), 32'd1);
    chk("alt_seen_n", 32'(seen_src.size() >= 4), 32'd1);
    if (acc_src.size() >= 4 && seen_src.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("alt_acc_src", 32'(acc_src[i]), 32'(i % 2));
        chk("alt_m_src", 32'(seen_src[i]), 32'(i % 2));
      end

    // Single source, two known pixels.
    clear_logs();
    cyc(1'b1, 24'hFFC864, 1'b0, 24'h0, 1'b1);
    cyc(1'b1, 24'h64C864, 1'b0, 24'h0, 1'b1);
    idle(8);
    chk("single_latency", 32'(first_valid_edge - first_acc_edge), 32'd3);
    chk("single_count", 32'(seen_hue.size()), 32'd2);
    if (seen_hue.size() >= 2) begin
      chk("single_hue0", 32'(seen_hue[0] >> 4), 32'd38);
      chk("single_hue1", 32'(seen_hue[1] >> 4), 32'd120);
      chk("single_src0", 32'(seen_src[0]), 32'd0);
      chk("single_src1", 32'(seen_src[1]), 32'd0);
    end

    // Backpressure fills the credit pool, then drains through the strict-credit boundary.
    clear_logs();
    for (int i = 0; i < 10; i++) cyc(1'b1, 24'($urandom), 1'b1, 24'($urandom), 1'b0);
    chk("bp_accepts", 32'(acc_src.size()), 32'(DEPTH));
    for (int i = 0; i < 12; i++) cyc(1'b1, 24'($urandom), 1'b1, 24'($urandom), 1'b1);
    idle(10);

    for (int i = 0; i < 3000; i++) rnd_cyc((i / 500) % 2 == 0 ? 80 : 35);
    idle(10);

    // Reset with pixels in flight.
    for (int i = 0; i < 3; i++) cyc(1'b1, 24'($urandom), 1'b1, 24'($urandom), 1'b1);
    reset_mid();
    clear_logs();
    for (int i = 0; i < 40; i++) rnd_cyc(100);
    idle(10);
    chk("post_rst_results", 32'(seen_hue.size() > 0 && acc_rgb.size() > 0), 32'd1);
    if (seen_hue.size() > 0 && acc_rgb.size() > 0)
      chk("post_rst_first_hue", 32'(seen_hue[0]), 32'(hue16(acc_rgb[0])));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
